// File: rtl/srg_multicycle_control_if.sv
// rtl/srg_multicycle_control_if.sv - control unit <-> datapath signal bundle
interface srg_multicycle_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic [2:0] operation_select;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_enable;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal;
    logic       instr_done;
    logic [3:0] state;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output operation_select, alu_src_a, alu_src_b, pc_source,
               pc_write, pc_write_cond, pc_enable, i_or_d, mem_read,
               mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               illegal, instr_done, state
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  operation_select, alu_src_a, alu_src_b, pc_source,
               pc_write, pc_write_cond, pc_enable, i_or_d, mem_read,
               mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               illegal, instr_done, state
    );
endinterface

// File: rtl/srg_multicycle_control.sv
// rtl/srg_multicycle_control.sv - multicycle MIPS main control Moore FSM
module srg_multicycle_control (
    input  logic                           clk,
    input  logic                           rst,
    srg_multicycle_control_if.master       bus
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  RTEXEC = 4'd6,  RTWB   = 4'd7,
        BEQ    = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11
    } state_t;

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b110;
    localparam logic [2:0] OP_CARRY = 3'b111;

    state_t     state_q, state_d;
    logic [2:0] funct_q;
    logic       illegal_q, done_q;
    logic       illegal_d, done_d;

    logic [2:0] funct_code;
    logic       funct_legal;

    logic       pc_write_raw, mem_read_raw, mem_write_raw, ir_write_raw, reg_write_raw;

    always_comb begin
        funct_code  = OP_AND;
        funct_legal = 1'b1;
        case (bus.funct)
            6'h20:   funct_code = OP_ADD;
            6'h22:   funct_code = OP_SUB;
            6'h24:   funct_code = OP_AND;
            6'h25:   funct_code = OP_OR;
            6'h2A:   funct_code = OP_CARRY;
            default: funct_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            funct_q   <= 3'b000;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            done_q    <= done_d;
            if (state_q == DECODE)
                funct_q <= funct_code;
        end
    end

    always_comb begin
        state_d              = FETCH;
        illegal_d            = 1'b0;
        done_d               = 1'b0;
        bus.operation_select = OP_AND;
        bus.alu_src_a        = 1'b0;
        bus.alu_src_b        = 2'b00;
        bus.pc_source        = 2'b00;
        bus.pc_write_cond    = 1'b0;
        bus.i_or_d           = 1'b0;
        bus.reg_dst          = 1'b0;
        bus.mem_to_reg       = 1'b0;
        pc_write_raw         = 1'b0;
        mem_read_raw         = 1'b0;
        mem_write_raw        = 1'b0;
        ir_write_raw         = 1'b0;
        reg_write_raw        = 1'b0;
        case (state_q)
            FETCH: begin
                mem_read_raw         = 1'b1;
                bus.alu_src_b        = 2'b01;
                bus.operation_select = OP_ADD;
                ir_write_raw         = bus.mem_ready;
                pc_write_raw         = bus.mem_ready;
                state_d              = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                bus.alu_src_b        = 2'b11;
                bus.operation_select = OP_ADD;
                case (bus.opcode)
                    6'h23, 6'h2B: state_d = MEMADR;
                    6'h04:        state_d = BEQ;
                    6'h08:        state_d = ADDIEX;
                    6'h02:        state_d = JUMP;
                    6'h00: begin
                        state_d   = funct_legal ? RTEXEC : FETCH;
                        illegal_d = ~funct_legal;
                    end
                    default:      illegal_d = 1'b1;
                endcase
            end
            MEMADR: begin
                bus.alu_src_a        = 1'b1;
                bus.alu_src_b        = 2'b10;
                bus.operation_select = OP_ADD;
                state_d              = (bus.opcode == 6'h23) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                bus.i_or_d   = 1'b1;
                mem_read_raw = 1'b1;
                state_d      = bus.mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                reg_write_raw  = 1'b1;
                bus.mem_to_reg = 1'b1;
                done_d         = 1'b1;
            end
            MEMWR: begin
                bus.i_or_d    = 1'b1;
                mem_write_raw = 1'b1;
                state_d       = bus.mem_ready ? FETCH : MEMWR;
                done_d        = bus.mem_ready;
            end
            RTEXEC: begin
                bus.alu_src_a        = 1'b1;
                bus.operation_select = funct_q;
                state_d              = RTWB;
            end
            RTWB: begin
                reg_write_raw = 1'b1;
                bus.reg_dst   = 1'b1;
                done_d        = 1'b1;
            end
            BEQ: begin
                bus.alu_src_a        = 1'b1;
                bus.operation_select = OP_SUB;
                bus.pc_source        = 2'b01;
                bus.pc_write_cond    = 1'b1;
                done_d               = 1'b1;
            end
            ADDIEX: begin
                bus.alu_src_a        = 1'b1;
                bus.alu_src_b        = 2'b10;
                bus.operation_select = OP_ADD;
                state_d              = ADDIWB;
            end
            ADDIWB: begin
                reg_write_raw = 1'b1;
                done_d        = 1'b1;
            end
            JUMP: begin
                pc_write_raw  = 1'b1;
                bus.pc_source = 2'b10;
                done_d        = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    // Write enables are gated by reset so an asynchronous abort never lets one glitch high.
    assign bus.pc_write   = pc_write_raw  & ~rst;
    assign bus.mem_read   = mem_read_raw  & ~rst;
    assign bus.mem_write  = mem_write_raw & ~rst;
    assign bus.ir_write   = ir_write_raw  & ~rst;
    assign bus.reg_write  = reg_write_raw & ~rst;
    assign bus.pc_enable  = ~rst & (pc_write_raw | (bus.pc_write_cond & bus.zero));
    assign bus.illegal    = illegal_q;
    assign bus.instr_done = done_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_srg_multicycle_control.sv
// tb/tb_srg_multicycle_control.sv - table-driven bench for srg_multicycle_control
module tb_srg_multicycle_control;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    srg_multicycle_control_if bus ();
    srg_multicycle_control dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic [23:0] exp;
    } row_t;

    row_t rows[$];
    int total = 0;
    int bad   = 0;

    // ctl order: pc_write pc_write_cond pc_enable i_or_d mem_read mem_write ir_write reg_dst mem_to_reg reg_write
    localparam logic [9:0] C_F1  = 10'b1010101000;
    localparam logic [9:0] C_F0  = 10'b0000100000;
    localparam logic [9:0] C_0   = 10'b0000000000;
    localparam logic [9:0] C_MRD = 10'b0001100000;
    localparam logic [9:0] C_MWB = 10'b0000000011;
    localparam logic [9:0] C_MWR = 10'b0001010000;
    localparam logic [9:0] C_RWB = 10'b0000000101;
    localparam logic [9:0] C_BQ1 = 10'b0110000000;
    localparam logic [9:0] C_BQ0 = 10'b0100000000;
    localparam logic [9:0] C_AWB = 10'b0000000001;
    localparam logic [9:0] C_J   = 10'b1010000000;

    function automatic logic [23:0] actual();
        return {bus.state, bus.operation_select, bus.alu_src_a, bus.alu_src_b, bus.pc_source,
                bus.pc_write, bus.pc_write_cond, bus.pc_enable, bus.i_or_d, bus.mem_read,
                bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write,
                bus.illegal, bus.instr_done};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic rdy,
                       input logic [3:0] st, input logic [2:0] alu, input logic sa,
                       input logic [1:0] sb, input logic [1:0] ps, input logic [9:0] ctl,
                       input logic ill, input logic done);
        row_t r;
        r.op = op; r.fn = fn; r.z = z; r.rdy = rdy;
        r.exp = {st, alu, sa, sb, ps, ctl, ill, done};
        rows.push_back(r);
    endtask

    task automatic t_fetch(input logic rdy, input logic ill, input logic done);
        add(6'h00, 6'h00, 1'b0, rdy, 4'd0, 3'b010, 1'b0, 2'b01, 2'b00, rdy ? C_F1 : C_F0, ill, done);
    endtask
    task automatic t_dec(input logic [5:0] op, input logic [5:0] fn);
        add(op, fn, 1'b0, 1'b0, 4'd1, 3'b010, 1'b0, 2'b11, 2'b00, C_0, 1'b0, 1'b0);
    endtask
    task automatic t_madr(input logic [5:0] op);
        add(op, 6'h00, 1'b0, 1'b0, 4'd2, 3'b010, 1'b1, 2'b10, 2'b00, C_0, 1'b0, 1'b0);
    endtask
    task automatic t_mrd(input logic rdy);
        add(6'h23, 6'h00, 1'b0, rdy, 4'd3, 3'b000, 1'b0, 2'b00, 2'b00, C_MRD, 1'b0, 1'b0);
    endtask
    task automatic t_mwb();
        add(6'h23, 6'h00, 1'b0, 1'b0, 4'd4, 3'b000, 1'b0, 2'b00, 2'b00, C_MWB, 1'b0, 1'b0);
    endtask
    task automatic t_mwr(input logic rdy);
        add(6'h2B, 6'h00, 1'b0, rdy, 4'd5, 3'b000, 1'b0, 2'b00, 2'b00, C_MWR, 1'b0, 1'b0);
    endtask
    task automatic t_rtex(input logic [5:0] fn, input logic [2:0] alu);
        add(6'h00, fn, 1'b1, 1'b1, 4'd6, alu, 1'b1, 2'b00, 2'b00, C_0, 1'b0, 1'b0);
    endtask
    task automatic t_rtwb();
        add(6'h00, 6'h00, 1'b0, 1'b1, 4'd7, 3'b000, 1'b0, 2'b00, 2'b00, C_RWB, 1'b0, 1'b0);
    endtask
    task automatic t_beq(input logic z);
        add(6'h04, 6'h00, z, 1'b0, 4'd8, 3'b110, 1'b1, 2'b00, 2'b01, z ? C_BQ1 : C_BQ0, 1'b0, 1'b0);
    endtask
    task automatic t_aex();
        add(6'h08, 6'h00, 1'b0, 1'b0, 4'd9, 3'b010, 1'b1, 2'b10, 2'b00, C_0, 1'b0, 1'b0);
    endtask
    task automatic t_awb();
        add(6'h08, 6'h00, 1'b0, 1'b0, 4'd10, 3'b000, 1'b0, 2'b00, 2'b00, C_AWB, 1'b0, 1'b0);
    endtask
    task automatic t_jmp();
        add(6'h02, 6'h00, 1'b0, 1'b0, 4'd11, 3'b000, 1'b0, 2'b00, 2'b10, C_J, 1'b0, 1'b0);
    endtask

    initial begin
        // sub, MemReady tied high
        t_fetch(1, 0, 0); t_dec(6'h00, 6'h22); t_rtex(6'h22, 3'b110); t_rtwb();
        // lw with three wait cycles in MEMRD
        t_fetch(1, 0, 1); t_dec(6'h23, 6'h00); t_madr(6'h23);
        t_mrd(0); t_mrd(0); t_mrd(0); t_mrd(1); t_mwb();
        // beq taken then not taken
        t_fetch(1, 0, 1); t_dec(6'h04, 6'h00); t_beq(1);
        t_fetch(1, 0, 1); t_dec(6'h04, 6'h00); t_beq(0);
        // illegal opcode, then illegal funct
        t_fetch(1, 0, 1); t_dec(6'h3F, 6'h20);
        t_fetch(1, 1, 0); t_dec(6'h00, 6'h27);
        // j then addi back to back
        t_fetch(1, 1, 0); t_dec(6'h02, 6'h00); t_jmp();
        t_fetch(1, 0, 1); t_dec(6'h08, 6'h00); t_aex(); t_awb();
        // sw with one FETCH wait
        t_fetch(0, 0, 1); t_fetch(1, 0, 0); t_dec(6'h2B, 6'h00); t_madr(6'h2B); t_mwr(1);
        // or: funct changes after DECODE must not alter the op
        t_fetch(1, 0, 1); t_dec(6'h00, 6'h25); t_rtex(6'h20, 3'b001); t_rtwb();
        // carry
        t_fetch(1, 0, 1); t_dec(6'h00, 6'h2A); t_rtex(6'h2A, 3'b111); t_rtwb();
        // sw lead-in for the mid-MEMWR reset
        t_fetch(1, 0, 1); t_dec(6'h2B, 6'h00); t_madr(6'h2B);

        bus.opcode = 6'h00; bus.funct = 6'h00; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("reset_state", {28'd0, bus.state}, 32'd0);
        check("reset_enables", {22'd0, bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write,
              bus.pc_enable, bus.reg_write, bus.illegal, bus.instr_done, 2'b00}, 32'd0);
        check("reset_fetch_mux", {26'd0, bus.operation_select, bus.alu_src_b, bus.alu_src_a},
              {26'd0, 3'b010, 2'b01, 1'b0});
        rst = 1'b0;

        for (int i = 0; i < rows.size(); i++) begin
            bus.opcode = rows[i].op; bus.funct = rows[i].fn;
            bus.zero = rows[i].z; bus.mem_ready = rows[i].rdy;
            #4;
            check($sformatf("row%0d", i), {8'd0, actual()}, {8'd0, rows[i].exp});
            @(posedge clk); #1;
        end

        // mid-MEMWR asynchronous reset
        bus.opcode = 6'h2B; bus.mem_ready = 1'b1;
        #1;
        check("memwr_pre", {27'd0, bus.state, bus.mem_write}, {27'd0, 4'd5, 1'b1});
        #1 rst = 1'b1;
        #1;
        check("memwr_abort", {26'd0, bus.state, bus.mem_write, bus.mem_read},
              {26'd0, 4'd0, 1'b0, 1'b0});
        @(posedge clk); #1;
        check("abort_no_done", {28'd0, bus.state, bus.ir_write, bus.pc_enable, bus.instr_done} >> 0,
              32'd0);
        rst = 1'b0;
        #3;
        check("release_fetch", {23'd0, bus.state, bus.mem_read, bus.alu_src_b, bus.operation_select},
              {23'd0, 4'd0, 1'b1, 2'b01, 3'b010});
        @(posedge clk); #1;
        check("release_decode", {28'd0, bus.state}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/srg_multicycle_control.md
# srg_multicycle_control

Multicycle MIPS main control unit: the issuing end of the 32-bit ALU's 3-bit operation-select interface, and the sequencer for the shared-memory multicycle datapath. It is a Moore FSM. It steps each instruction through fetch, decode, execute, memory and writeback. Per state it drives the ALU operation code, the datapath mux selects and the write enables, and it waits on a memory ready handshake.

## Interface
- No parameters. ALU codes are fixed: AND=000, OR=001, ADD=010, SUB=110, CARRY=111.
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high; forces state FETCH
- Opcode  in  6  instruction[31:26] from the datapath IR; stable from DECODE to end of instruction
- Funct  in  6  instruction[5:0] from the datapath IR
- Zero  in  1  ALU zero flag, same cycle
- MemReady  in  1  memory handshake; the access completes in the cycle it is high
- OperationSelect  out  3  ALU operation code
- ALUSrcA  out  1  0=PC, 1=register A
- ALUSrcB  out  2  00=B, 01=constant 4, 10=sign-extended immediate, 11=immediate<<2
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
- PCWrite, PCWriteCond, PCEnable  out  1 each  PCEnable = PCWrite | (PCWriteCond & Zero)
- IorD, MemRead, MemWrite, IRWrite  out  1 each  memory controls
- RegDst, MemtoReg, RegWrite  out  1 each  register-file controls
- Illegal  out  1  registered one-cycle pulse on an unsupported opcode/funct
- InstrDone  out  1  registered one-cycle pulse after an instruction's final state

## Operation
- 4-bit state register with the following encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5
  - RTEXEC 6, RTWB 7, BEQ 8, ADDIEX 9, ADDIWB 10, JUMP 11
  - Codes 12–15 go to FETCH on the next edge.
- Every output not listed for a state is 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, Op=ADD, PCSource=00. IRWrite=PCWrite=MemReady. Stay until MemReady, then go to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, Op=ADD (branch target). Register the funct decode: 0x20→ADD, 0x22→SUB, 0x24→AND, 0x25→OR, 0x2A→CARRY. Next state by opcode:
  - 0x23/0x2B → MEMADR
  - 0x00 with a legal funct → RTEXEC
  - 0x04 → BEQ
  - 0x08 → ADDIEX
  - 0x02 → JUMP
  - Anything else → FETCH, with Illegal=1 on the next cycle.
- MEMADR: ALUSrcA=1, ALUSrcB=10, Op=ADD. Go to MEMRD for 0x23, MEMWR for 0x2B.
- MEMRD: IorD=1, MemRead=1. Wait for MemReady, then go to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Go to FETCH.
- MEMWR: IorD=1, MemWrite=1. Wait for MemReady, then go to FETCH.
- RTEXEC: ALUSrcA=1, ALUSrcB=00, Op=registered funct code. Go to RTWB.
- RTWB: RegWrite=1, RegDst=1, MemtoReg=0. Go to FETCH.
- BEQ: ALUSrcA=1, ALUSrcB=00, Op=SUB, PCSource=01, PCWriteCond=1. Go to FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, Op=ADD. Go to ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Go to FETCH.
- JUMP: PCWrite=1, PCSource=10. Go to FETCH.
- InstrDone is set on the edge leaving MEMWB, MEMWR (with MemReady), RTWB, BEQ, ADDIWB or JUMP. It is not set for illegal instructions.

## Timing
- Reset state: state=FETCH, registered funct=000, Illegal=0, InstrDone=0.
- While Reset is high, these are forced to 0: MemRead, MemWrite, IRWrite, PCWrite, PCEnable, RegWrite. Mux selects show FETCH values.
- Reset asserted mid-instruction aborts it immediately (asynchronously), with no write enable glitching high. The first FETCH starts on the first edge after deassertion.
- Control outputs are combinational from state, registered funct, Zero and MemReady. Only PCEnable, IRWrite and PCWrite depend on inputs in the same cycle.
- Cycles per instruction with zero-wait memory: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each low-MemReady cycle in FETCH/MEMRD/MEMWR adds exactly 1 cycle.
- MemReady is ignored outside FETCH, MEMRD and MEMWR.
- Opcode/Funct are sampled only in DECODE. Later changes do not alter the ALU op.
- Illegal and InstrDone are never high in the same cycle.

## Test plan
- Reset mid-MEMWR with MemReady=1 → MemWrite drops to 0 immediately, no write occurs, state=0. After release, FETCH shows MemRead=1, ALUSrcB=01, Op=010.
- R-type funct 0x22 (sub), MemReady tied 1 → states 0,1,6,7. Op=110 in RTEXEC, RegWrite=1 with RegDst=1 in RTWB, InstrDone pulses once, 4 cycles total.
- lw (0x23) with MemReady low 3 cycles in MEMRD → states 0,1,2,3,3,3,3,4. RegWrite=1 with MemtoReg=1 only in MEMWB, 8 cycles total.
- beq (0x04), Zero=1 vs Zero=0 → BEQ shows Op=110 and PCSource=01. PCEnable=1 only when Zero=1, 3 cycles either way.
- Opcode 0x3F, or opcode 0x00 with funct 0x27 → DECODE then FETCH. Illegal pulses 1 cycle, no write enable asserted, InstrDone stays 0.
- Back-to-back j (0x02) then addi (0x08) → JUMP shows PCWrite=1, PCSource=10. addi follows as states 0,1,9,10 with ALUSrcB=10, Op=010.
